// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes and multiply-sequencer state encoding.
// Latency: n/a. Backpressure: n/a.
// Imported by the EX-stage helpers and the ALU.
package cpu_pkg;

    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;
    localparam logic [3:0] ALU_OP_XOR = 4'b0101;
    localparam logic [3:0] ALU_OP_SLL = 4'b1000;
    localparam logic [3:0] ALU_OP_SRL = 4'b1010;
    localparam logic [3:0] ALU_OP_SRA = 4'b1011;

    typedef enum logic [1:0] {
        MS_IDLE  = 2'd0,
        MS_ADD   = 2'd1,
        MS_SHIFT = 2'd2,
        MS_DONE  = 2'd3
    } ms_state_t;

endpackage

// File: rtl/alu.sv
// Shared execute-stage ALU (combinational).
// Latency: 0 cycles, result valid in the same cycle as the operands.
// Backpressure: none; always accepts operands.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] c
);

    always_comb begin
        c = '0;
        case (op)
            ALU_OP_AND: c = a & b;
            ALU_OP_OR:  c = a | b;
            ALU_OP_ADD: c = a + b;
            ALU_OP_SUB: c = a - b;
            ALU_OP_XOR: c = a ^ b;
            ALU_OP_SLL: c = a << b[4:0];
            ALU_OP_SRL: c = a >> b[4:0];
            ALU_OP_SRA: c = $signed(a) >>> b[4:0];
            default:    c = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier that borrows the EX-stage ALU; keeps low XLEN product bits.
// Latency: done in cycle 2k+1 after start (k = multiplier bit length with EARLY_EXIT, else XLEN).
// Backpressure: start accepted only in IDLE and never queued; busy stalls the pipeline meanwhile.
module alu_mul_sequencer
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] alu_c,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic            alu_bsel,
    output logic            alu_grant,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    ms_state_t        state;
    logic [XLEN-1:0]  prod;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  result_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= MS_IDLE;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (flush) begin
            state <= MS_IDLE;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (start) begin
                        prod   <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        cnt    <= '0;
                        state  <= (EARLY_EXIT && op_b == '0) ? MS_DONE : MS_ADD;
                    end
                end
                MS_ADD: begin
                    if (mplier[0]) begin
                        prod <= alu_c;
                    end
                    state <= MS_SHIFT;
                end
                MS_SHIFT: begin
                    mcand  <= alu_c;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Bits still to be consumed are mplier[XLEN-1:1] after this shift.
                    if (cnt == CNT_LAST || (EARLY_EXIT && mplier[XLEN-1:1] == '0)) begin
                        state <= MS_DONE;
                    end else begin
                        state <= MS_ADD;
                    end
                end
                MS_DONE: begin
                    result_q <= prod;
                    state    <= MS_IDLE;
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_OP_AND;
        case (state)
            MS_ADD: begin
                alu_a  = prod;
                alu_b  = mcand;
                alu_op = ALU_OP_ADD;
            end
            MS_SHIFT: begin
                alu_a  = mcand;
                alu_b  = XLEN'(1);
                alu_op = ALU_OP_SLL;
            end
            default: ;
        endcase
    end

    assign alu_bsel  = 1'b0;
    assign alu_grant = (state == MS_ADD) || (state == MS_SHIFT);
    assign busy      = (state != MS_IDLE);
    // A flush landing in DONE cancels the completion, so the bypass is gated too.
    assign done      = (state == MS_DONE) && !flush;
    assign result    = done ? prod : result_q;

endmodule
